// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one cacheline memory port between I-cache and D-cache.
// Optional build macro ARB_ROUND_ROBIN_EN: tie-break alternates instead of D-first.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   i_req;
    logic   d_req;
    logic   pick_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    // Winner of the next grant taken from IDLE (1 = D-cache)
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = d_req & (~i_req | ~last_grant);
`else
        pick_d = d_req;
`endif
    end

    // Grant FSM: one whole-line transaction at a time, back to IDLE on mem_resp
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        state      <= pick_d ? SERVE_D : SERVE_I;
                        last_grant <= pick_d;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Forward the granted side to memory and route the response back to it only
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rdata   = '0;
        i_resp    = 1'b0;
        d_rdata   = '0;
        d_resp    = 1'b0;
        if (!rst) begin
            unique case (state)
                SERVE_I: begin
                    mem_read  = i_read;
                    mem_write = i_write;
                    mem_addr  = i_addr;
                    mem_wdata = i_wdata;
                    i_rdata   = mem_rdata;
                    i_resp    = mem_resp;
                end
                SERVE_D: begin
                    mem_read  = d_read;
                    mem_write = d_write;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    d_rdata   = mem_rdata;
                    d_resp    = mem_resp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed checks of grant order, forwarding, reset and stray resp.
// Expected tie winner follows ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, i_write, d_read, d_write;
    logic [31:0]  i_addr, d_addr, mem_addr;
    logic [255:0] i_wdata, d_wdata, mem_wdata, mem_rdata;
    logic [255:0] i_rdata, d_rdata;
    logic         i_resp, d_resp, mem_read, mem_write, mem_resp;

    int  n_run = 0;
    int  n_fail = 0;
    bit  tb_last = 1'b0;

    localparam logic [255:0] CAFE = {8{32'hCAFE_BABE}};
    localparam logic [255:0] A5   = {8{32'hA5A5_A5A5}};

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    // Requester contract: never read and write together on one side
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(i_read && i_write)) else $error("i read+write");
            assert (!(d_read && d_write)) else $error("d read+write");
        end
    end

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mrd"}, 256'(mem_read), 0);
        chk({tag, "_mwr"}, 256'(mem_write), 0);
        chk({tag, "_madr"}, 256'(mem_addr), 0);
        chk({tag, "_mwd"}, mem_wdata, 0);
        chk({tag, "_ird"}, i_rdata, 0);
        chk({tag, "_drd"}, d_rdata, 0);
        chk({tag, "_iresp"}, 256'(i_resp), 0);
        chk({tag, "_dresp"}, 256'(d_resp), 0);
    endtask

    // Starts in an IDLE cycle with the read request(s) already raised.
    // Serves one read, then drops the served side's request.
    task automatic serve_one(input string tag, input bit is_d,
                             input logic [31:0] addr,
                             input logic [255:0] rd);
        step();
        chk({tag, "_mrd"}, 256'(mem_read), 1);
        chk({tag, "_madr"}, 256'(mem_addr), 256'(addr));
        mem_resp  = 1;
        mem_rdata = rd;
        #1;
        chk({tag, "_iresp"}, 256'(i_resp), 256'(!is_d));
        chk({tag, "_dresp"}, 256'(d_resp), 256'(is_d));
        chk({tag, "_ird"}, i_rdata, is_d ? 256'(0) : rd);
        chk({tag, "_drd"}, d_rdata, is_d ? rd : 256'(0));
        tb_last = is_d;
        step();
        mem_resp = 0;
        mem_rdata = '0;
        if (is_d) d_read = 0;
        else i_read = 0;
        #1;
        chk({tag, "_idle"}, 256'(mem_read), 0);
    endtask

    function automatic bit tie_wins_d();
`ifdef ARB_ROUND_ROBIN_EN
        return !tb_last;
`else
        return 1'b1;
`endif
    endfunction

    bit first_d;

    initial begin
        // 1: reset with random inputs
        rst = 1;
        for (int c = 0; c < 2; c++) begin
            i_read = 1'($urandom); i_write = 1'($urandom);
            d_read = 1'($urandom); d_write = 1'($urandom);
            i_addr = $urandom; d_addr = $urandom;
            i_wdata = {8{$urandom}}; d_wdata = {8{$urandom}};
            mem_rdata = {8{$urandom}}; mem_resp = 1'($urandom);
            step();
            chk_all_zero("rst");
            chk("rst_state", 256'(dut.state), 0);
        end
        clear_in();
        rst = 0;
        tb_last = 0;
        step();
        chk_all_zero("post_rst");

        // 2: I-cache read, resp 5 cycles after request
        i_read = 1; i_addr = 32'h40;
        #1;
        chk("t2_lat0", 256'(mem_read), 0);
        step();
        for (int c = 1; c < 5; c++) begin
            chk("t2_mrd", 256'(mem_read), 1);
            chk("t2_madr", 256'(mem_addr), 256'h40);
            chk("t2_dresp", 256'(d_resp), 0);
            chk("t2_iresp", 256'(i_resp), 0);
            step();
        end
        mem_resp = 1; mem_rdata = CAFE;
        #1;
        chk("t2_iresp1", 256'(i_resp), 1);
        chk("t2_ird", i_rdata, CAFE);
        chk("t2_dresp1", 256'(d_resp), 0);
        tb_last = 0;
        step();
        clear_in();
        #1;
        chk("t2_after", 256'(mem_read), 0);
        chk("t2_iresp0", 256'(i_resp), 0);

        // 3: D writeback then D fetch right after
        d_write = 1; d_addr = 32'h100; d_wdata = A5;
        step();
        chk("t3_mwr", 256'(mem_write), 1);
        chk("t3_mrd", 256'(mem_read), 0);
        chk("t3_madr", 256'(mem_addr), 256'h100);
        chk("t3_mwd", mem_wdata, A5);
        step();
        mem_resp = 1;
        #1;
        chk("t3_dresp", 256'(d_resp), 1);
        chk("t3_iresp", 256'(i_resp), 0);
        tb_last = 1;
        step();
        mem_resp = 0;
        d_write = 0; d_wdata = '0;
        d_read = 1; d_addr = 32'h200;
        #1;
        chk("t3_gap_wr", 256'(mem_write), 0);
        chk("t3_gap_rd", 256'(mem_read), 0);
        serve_one("t3_rd", 1, 32'h200, {8{32'h1234_5678}});
        clear_in();

        // 4: two ties in a row
        for (int t = 0; t < 2; t++) begin
            i_read = 1; i_addr = 32'h300;
            d_read = 1; d_addr = 32'h400;
            first_d = tie_wins_d();
            serve_one($sformatf("t4_%0d_a", t), first_d,
                      first_d ? 32'h400 : 32'h300, {8{32'h0000_1111}});
            serve_one($sformatf("t4_%0d_b", t), !first_d,
                      first_d ? 32'h300 : 32'h400, {8{32'h0000_2222}});
        end
        clear_in();

        // 5: reset while serving D, then a normal I read
        d_read = 1; d_addr = 32'h500;
        step();
        chk("t5_mrd", 256'(mem_read), 1);
        step();
        rst = 1;
        step();
        rst = 0;
        d_read = 0; d_addr = '0;
        tb_last = 0;
        #1;
        chk("t5_mrd0", 256'(mem_read), 0);
        chk("t5_mwr0", 256'(mem_write), 0);
        chk("t5_dresp0", 256'(d_resp), 0);
        chk("t5_state", 256'(dut.state), 0);
        i_read = 1; i_addr = 32'h600;
        serve_one("t5_i", 0, 32'h600, {8{32'hDEAD_0001}});
        clear_in();

        // 6: stray mem_resp in IDLE
        step();
        mem_resp = 1; mem_rdata = CAFE;
        #1;
        chk("t6_iresp", 256'(i_resp), 0);
        chk("t6_dresp", 256'(d_resp), 0);
        chk("t6_ird", i_rdata, 0);
        step();
        mem_resp = 0;
        #1;
        chk("t6_state", 256'(dut.state), 0);
        chk("t6_mrd", 256'(mem_read), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
